// File: rtl/sum_result_buffer_pkg.sv
// Shared defaults for the adder result buffer: result width, adder latency and FIFO depth.
// Also holds the per-cycle event record the top level decodes from its inputs.
package sum_result_buffer_pkg;

    localparam int SUM_WIDTH_DEF     = 32;
    localparam int ADDER_LATENCY     = 5;
    localparam int SUM_BUF_DEPTH_DEF = 8;

    // Decoded per-cycle buffer events.
    typedef struct packed {
        logic wr;     // result written into the array
        logic pop;    // downstream transfer (array head or bypassed result)
        logic unsol;  // result arrived with nothing in flight and was kept
        logic err;    // overflow or unsolicited result
    } buf_evt_t;

endpackage

// File: rtl/sum_buf_mem.sv
// DEPTH x WIDTH register array for the result buffer.
// Synchronous write, asynchronous read, so the head entry is visible without a read cycle.
module sum_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sum_result_buffer.sv
// Result FIFO behind the pipelined adder, with issue credits so stored plus in-flight results never exceed DEPTH.
// Optional SUM_RESULT_BUFFER_BYPASS_EN: an arriving result is presented in the same cycle when the FIFO is empty.
module sum_result_buffer
    import sum_result_buffer_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH_DEF,
    parameter int DEPTH = SUM_BUF_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue,
    output logic                   issue_ok,
    input  logic                   in_v,
    input  logic [WIDTH-1:0]       in_sum,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_CX = (CW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    reserved;
    logic [CW-1:0]    reserved_nxt;
    logic [CW:0]      reserved_sum;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             issue_acc;
    logic             byp_take;
    logic             rd_adv;
    buf_evt_t         evt;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign issue_ok  = (reserved < DEPTH_C);
    assign issue_acc = issue && issue_ok;

    // m_valid/m_ready: one result transfers on each rising edge where both are high;
    // m_valid and m_data stay stable until that transfer, and there is no other way to drop m_valid.
`ifdef SUM_RESULT_BUFFER_BYPASS_EN
    logic byp;
    assign byp      = in_v && empty;
    assign m_valid  = !empty || byp;
    assign m_data   = !empty ? rd_data : (byp ? in_sum : '0);
    assign byp_take = byp && m_ready;
`else
    assign m_valid  = !empty;
    assign m_data   = !empty ? rd_data : '0;
    assign byp_take = 1'b0;
`endif

    always_comb begin
        evt       = '0;
        evt.pop   = m_valid && m_ready;
        evt.wr    = in_v && !full && !byp_take;
        // A stored unsolicited result still occupies a slot, so it takes a credit too.
        evt.unsol = in_v && !full && (reserved == count);
        evt.err   = in_v && (full || (reserved == count));
    end

    assign rd_adv = evt.pop && !empty;

    // Credit total; only an unsolicited arrival alongside an accepted issue can overshoot DEPTH.
    always_comb begin
        reserved_sum = {1'b0, reserved} + (CW + 1)'(issue_acc)
                     + (CW + 1)'(evt.unsol) - (CW + 1)'(evt.pop);
        reserved_nxt = (reserved_sum > DEPTH_CX) ? DEPTH_C : reserved_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            reserved <= '0;
            err      <= 1'b0;
        end else begin
            if (evt.wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count + CW'(evt.wr) - CW'(rd_adv);
            reserved <= reserved_nxt;
            if (evt.err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    sum_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (evt.wr),
        .waddr (wr_ptr),
        .wdata (in_sum),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sum_result_buffer.sv
// Bench for sum_result_buffer: an adder delay line feeds results, a scoreboard queue checks order and data,
// and a credit/occupancy model checks count, issue_ok and err every cycle.
module tb_sum_result_buffer;
    import sum_result_buffer_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int LAT   = ADDER_LATENCY;

    logic         clk;
    logic         rst_n;
    logic         issue;
    logic         issue_ok;
    logic         in_v;
    logic [W-1:0] in_sum;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [3:0]   count;
    logic         err;
    logic         err_clr;

    sum_result_buffer #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (issue),
        .issue_ok (issue_ok),
        .in_v     (in_v),
        .in_sum   (in_sum),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .err      (err),
        .err_clr  (err_clr)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           checks;
    int           failures;
    int           cyc;
    int           res_m;
    int           acc_total;
    logic         err_m;
    logic         seq_mode;
    logic [W-1:0] next_val;
    logic [W-1:0] exp_q[$];
    int           pend_t[$];
    logic [W-1:0] pend_d[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; drives one cycle, checks it, advances the models.
    task automatic cycle(input logic iss, input logic rdy, input logic clr,
                         input logic fv, input logic [W-1:0] fd);
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] exp_md;
        logic         exp_ok;
        logic         exp_mv;
        logic         byp;
        logic         pop;
        logic         acc;
        logic         unsol;
        int           sz;
        int           res_old;
        v = fv;
        d = fd;
        if (!fv && pend_t.size() != 0 && pend_t[0] == cyc) begin
            v = 1'b1;
            d = pend_d.pop_front();
            void'(pend_t.pop_front());
        end
        issue   = iss;
        m_ready = rdy;
        err_clr = clr;
        in_v    = v;
        in_sum  = d;
        #3;
        sz      = exp_q.size();
        res_old = res_m;
        exp_ok  = (res_m < DEPTH);
        byp     = 1'b0;
`ifdef SUM_RESULT_BUFFER_BYPASS_EN
        byp = v && (sz == 0);
`endif
        exp_mv = (sz != 0) || byp;
        check("count", 32'(count), 32'(sz));
        check("m_valid", 32'(m_valid), 32'(exp_mv));
        check("issue_ok", 32'(issue_ok), 32'(exp_ok));
        check("err", 32'(err), 32'(err_m));
        pop = exp_mv && rdy;
        if (pop) begin
            exp_md = (sz != 0) ? exp_q.pop_front() : d;
            check("m_data", m_data, exp_md);
        end
        if (v && sz < DEPTH && !(byp && rdy)) begin
            exp_q.push_back(d);
        end
        acc = iss && exp_ok;
        if (acc) begin
            pend_t.push_back(cyc + LAT);
            if (seq_mode) begin
                pend_d.push_back(next_val);
                next_val = next_val + 1;
            end else begin
                pend_d.push_back($urandom());
            end
            acc_total++;
        end
        unsol = v && (res_old == sz) && (sz < DEPTH);
        res_m = res_m + int'(acc) + int'(unsol) - int'(pop);
        if (res_m > DEPTH) res_m = DEPTH;
        if (v && (sz == DEPTH || res_old == sz)) err_m = 1'b1;
        else if (clr) err_m = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_state(input string tag, input int cnt, input logic ok, input logic e);
        issue   = 1'b0;
        in_v    = 1'b0;
        in_sum  = '0;
        m_ready = 1'b0;
        err_clr = 1'b0;
        #1;
        check({tag, "_count"}, 32'(count), 32'(cnt));
        check({tag, "_issue_ok"}, 32'(issue_ok), 32'(ok));
        check({tag, "_err"}, 32'(err), 32'(e));
        check({tag, "_m_valid"}, 32'(m_valid), 32'(cnt != 0));
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pend_t.size() != 0) && k < 100) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
            k++;
        end
        check({tag, "_drained"}, 32'(exp_q.size() + pend_t.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int base;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        res_m     = 0;
        acc_total = 0;
        err_m     = 1'b0;
        seq_mode  = 1'b0;
        next_val  = '0;
        rst_n     = 1'b0;
        issue     = 1'b0;
        in_v      = 1'b0;
        in_sum    = '0;
        m_ready   = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_issue_ok", 32'(issue_ok), 32'd1);
        rst_n = 1'b1;

        // Credit exhaustion: issue every cycle, nothing drained.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        expect_state("t1_full", 8, 1'b0, 1'b0);

        // Issue and pop together at reserved == DEPTH: issue ignored, credit returns next cycle.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        expect_state("t3_credit", 7, 1'b1, 1'b0);
        drain("t3a");

        // Write and pop together at count == 1.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        expect_state("t3_one", 1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        expect_state("t3_same", 1, 1'b1, 1'b0);
        drain("t3b");

        // Ordering and wrap: 20 sequential results, m_ready pattern 1,0,1.
        seq_mode = 1'b1;
        next_val = 32'h1;
        base     = acc_total;
        k        = 0;
        while (((acc_total - base) < 20 || exp_q.size() != 0 || pend_t.size() != 0) && k < 300) begin
            cycle((acc_total - base) < 20, (k % 3) != 1, 1'b0, 1'b0, '0);
            k++;
        end
        seq_mode = 1'b0;
        check("t2_issued", 32'(acc_total - base), 32'd20);
        check("t2_last_val", next_val, 32'h15);
        expect_state("t2_end", 0, 1'b1, 1'b0);

        // Errors: unsolicited result, clear, overflow.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        expect_state("t4_unsol", 1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        expect_state("t4_clr", 1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, W'($urandom_range(1000, 9999)));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        expect_state("t4_fill", 8, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        expect_state("t4_ovf", 7, 1'b1, 1'b1);
        drain("t4");

        // Reset mid-stream with five results stored.
        for (int i = 0; i < 10; i++) cycle(i < 5, 1'b0, 1'b0, 1'b0, '0);
        expect_state("t5_pre", 5, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_m_valid", 32'(m_valid), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_issue_ok", 32'(issue_ok), 32'd1);
        check("t5_m_data", m_data, 32'd0);
        exp_q.delete();
        pend_t.delete();
        pend_d.delete();
        res_m = 0;
        err_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
        expect_state("t5_unsol", 1, 1'b1, 1'b1);
        drain("t5");

        // Result arriving into an empty FIFO with m_ready high.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
`ifdef SUM_RESULT_BUFFER_BYPASS_EN
        expect_state("t6_byp", 0, 1'b1, 1'b1);
`else
        expect_state("t6_next", 1, 1'b1, 1'b1);
        check("t6_m_data", m_data, 32'h1234_5678);
`endif
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
